load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Data-side memory access stage between the controller and the memory module.
//  - Accepts one load/store request at a time from the controller over a valid/ready handshake.
//  - Drives the memory read/write ports.
//  - Waits out the fixed memory read latency.
//  - Returns a sign- or zero-extended load result selected by RV32I funct3.
// PARAMETERS
//  READ_LATENCY  1  cycles from read_address driven to read_data valid at memory output (1..7)
//  ADDR_W        32 byte-address width
// PORTS
//  clk            in   1       system clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  req_valid      in   1       controller presents a request
//  req_ready      out  1       LSU can accept a request this cycle
//  req_store      in   1       1 = store, 0 = load
//  req_funct3     in   3       RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
//  req_addr       in   ADDR_W  byte address
//  req_wdata      in   32      store data (low bytes used for SB/SH)
//  rsp_valid      out  1       one-cycle pulse: load data / store completion
//  rsp_rdata      out  32      extended load result (0 for stores)
//  rsp_err        out  1       misaligned access flag (valid with rsp_valid)
//  write_mem      out  1       memory write enable
//  funct3         out  3       access size to memory
//  write_address  out  32      memory write byte address
//  write_data     out  32      memory write data
//  read_address   out  32      memory read address, word-aligned ({addr[31:2],2'b00})
//  read_data      in   32      memory read word
// BEHAVIOUR
//  - Reset values (async, immediate):
//    - state=IDLE; req_ready=1.
//    - rsp_valid=0, rsp_rdata=0, rsp_err=0.
//    - write_mem=0, funct3=0, write_address=0, write_data=0, read_address=0.
//  - FSM states: IDLE, STORE, LOAD_WAIT, RESP.
//  - IDLE: req_ready=1.
//    - Handshake: req_valid&&req_ready at a rising edge captures the request.
//    - Store -> STORE. Load -> LOAD_WAIT, with wait counter loaded with READ_LATENCY.
//  - STORE: write_mem=1 for exactly one cycle with the captured addr/data/funct3 -> RESP.
//  - LOAD_WAIT: read_address held stable; counter decrements each cycle.
//    - At 0, read_data is sampled -> RESP.
//    - Load latency, handshake to rsp_valid: READ_LATENCY+1 cycles.
//  - RESP: rsp_valid=1 for one cycle -> IDLE.
//    - Store latency: 2 cycles.
//    - req_ready=0 in every state except IDLE, so no back-to-back overlap.
//  - Load extraction (byte lane = addr[1:0]):
//    - LB/LBU: byte lane; LH/LHU: half at addr[1]; LW: full word.
//    - LB/LH sign-extend; LBU/LHU zero-extend.
//  - Undefined funct3 (3'b011, 3'b110, 3'b111) acts as LW/SW; rsp_err unaffected.
//  - Misalignment: half with addr[0]=1, word with addr[1:0]!=0 (see CONFIGURATION).
//  - Requests are not accepted while req_valid drops mid-transaction; the captured copy is used.
//  - rst asserted mid-transaction aborts immediately:
//    - write_mem deasserts asynchronously.
//    - No rsp_valid is issued for the aborted request.
// CONFIGURATION
//  - LSU_MISALIGN_TRAP_EN defined: a misaligned request skips the memory access.
//    - No write_mem, no wait.
//    - Goes IDLE->RESP with rsp_err=1, rsp_rdata=0.
//  - Not defined: address low bits are force-aligned to the access size.
//    - Access proceeds normally; rsp_err is tied 0.
// TESTING
//  1. LW addr 0x10, mem[0x10]=0xDEADBEEF -> rsp_valid 2 cycles after handshake, rsp_rdata=0xDEADBEEF.
//  2. LB addr 0x13, word 0x80FF_0000 -> 0xFFFFFF80; LBU same -> 0x00000080.
//  3. LH addr 0x12, word 0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001.
//  4. SB addr 0x21 data 0x000000AB -> write_mem=1 one cycle, write_address=0x21, funct3=000.
//     - Then rsp_valid, rsp_rdata=0.
//  5. LW addr 0x22:
//     - macro on -> rsp_err=1, write_mem/read never issued.
//     - macro off -> read_address=0x20, rsp_err=0.
//  6. rst pulsed during LOAD_WAIT -> all outputs reset, no rsp_valid.
//     - Next request completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store stage; define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them
module load_store_unit #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_store_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              write_mem_o,
    output logic [2:0]        funct3_o,
    output logic [31:0]       write_address_o,
    output logic [31:0]       write_data_o,
    output logic [31:0]       read_address_o,
    input  logic [31:0]       read_data_i
);
    typedef enum logic [1:0] {IDLE, STORE, LOAD_WAIT, RESP} state_t;
    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        store_q, store_d;
    logic        err_q, err_d;
    logic [2:0]  f3_n;
    logic [31:0] addr_n, addr_a;
    logic        mis;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ext;

    // Decode the incoming request: undefined funct3 becomes a word access, then misalignment/alignment
    always_comb begin
        f3_n   = (req_funct3_i == 3'b011 || req_funct3_i[2:1] == 2'b11) ? 3'b010 : req_funct3_i;
        addr_n = 32'(req_addr_i);
`ifdef LSU_MISALIGN_TRAP_EN
        mis    = (f3_n[1:0] == 2'b01 && addr_n[0]) || (f3_n[1:0] == 2'b10 && addr_n[1:0] != 2'b00);
        addr_a = addr_n;
`else
        mis    = 1'b0;
        addr_a = {addr_n[31:2], f3_n[1] ? 2'b00 : {addr_n[1], addr_n[0] & ~f3_n[0]}};
`endif
    end

    // State register and captured request; async reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            store_q  <= store_d;
            err_q    <= err_d;
        end
    end

    // Next state and handshake outputs; write_mem is decoded from state so reset drops it at once
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        store_d     = store_q;
        err_d       = err_q;
        req_ready_o = state_q == IDLE;
        rsp_valid_o = state_q == RESP;
        write_mem_o = state_q == STORE;
        case (state_q)
            IDLE: if (req_valid_i) begin
                funct3_d = f3_n;
                addr_d   = addr_a;
                wdata_d  = req_wdata_i;
                store_d  = req_store_i;
                err_d    = mis;
                cnt_d    = LAT;
                state_d  = mis ? RESP : req_store_i ? STORE : LOAD_WAIT;
            end
            STORE: state_d = RESP;
            LOAD_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory read data is valid during RESP, so the load result is extracted from it there
    always_comb begin
        byte_v      = 8'(read_data_i >> {addr_q[1:0], 3'b000});
        half_v      = 16'(read_data_i >> {addr_q[1], 4'b0000});
        ext         = funct3_q[1] ? read_data_i :
                      funct3_q[0] ? {{16{~funct3_q[2] & half_v[15]}}, half_v} :
                                    {{24{~funct3_q[2] & byte_v[7]}}, byte_v};
        rsp_rdata_o = (rsp_valid_o && !store_q && !err_q) ? ext : '0;
        rsp_err_o   = rsp_valid_o & err_q;
    end

    assign funct3_o        = funct3_q;
    assign write_address_o = addr_q;
    assign write_data_o    = wdata_q;
    assign read_address_o  = {addr_q[31:2], 2'b00};
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table, reset-abort sequences and random traffic against a byte-array model
`timescale 1ns/1ps
module tb_load_store_unit;
    localparam int RL = 1;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] word;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wm;
        logic [31:0] waddr;
        logic [2:0]  fo;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wm;
        logic [31:0] waddr;
        logic [2:0]  fo;
        logic [31:0] raddr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, write_mem;
    logic [31:0] rsp_rdata, write_address, write_data, read_address, read_data;
    logic [2:0]  funct3;
    logic [7:0]  dmem [256];
    logic [7:0]  ref_b [256];
    logic [31:0] pipe [RL];
    int          total = 0;
    int          bad = 0;
    vec_t        tv [16];

    always #5 clk = ~clk;

    load_store_unit #(.READ_LATENCY(RL), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_store_i(req_store),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .write_mem_o(write_mem), .funct3_o(funct3), .write_address_o(write_address),
        .write_data_o(write_data), .read_address_o(read_address), .read_data_i(read_data)
    );

    function automatic logic [31:0] word_at(input logic [7:0] a);
        return {dmem[a | 8'd3], dmem[a | 8'd2], dmem[a | 8'd1], dmem[a & 8'hFC]};
    endfunction

    // Memory with a READ_LATENCY-deep registered read path
    always @(posedge clk) begin
        pipe[0] <= word_at(read_address[7:0]);
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign read_data = pipe[RL-1];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic check_reset(input string n);
        chk({n, "_ready"}, 32'(req_ready), 32'd1);
        chk({n, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({n, "_rdata"}, rsp_rdata, 32'd0);
        chk({n, "_err"}, 32'(rsp_err), 32'd0);
        chk({n, "_write_mem"}, 32'(write_mem), 32'd0);
        chk({n, "_funct3"}, 32'(funct3), 32'd0);
        chk({n, "_waddr"}, write_address, 32'd0);
        chk({n, "_wdata"}, write_data, 32'd0);
        chk({n, "_raddr"}, read_address, 32'd0);
    endtask

    function automatic int size_of(input logic [2:0] f);
        return (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : 4;
    endfunction

    // Reference: byte-addressed memory, access size from funct3, results by plain arithmetic
    function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int sz, al;
        logic [31:0] v;
        sz = size_of(f3);
        e = '{default: 0};
`ifdef LSU_MISALIGN_TRAP_EN
        e.err = (a % sz) != 0;
`endif
        al = int'(a) - int'(a % sz);
        e.raddr = a - a % 4;
        e.waddr = 32'(al);
        e.fo = sz == 1 ? 3'd0 : sz == 2 ? 3'd1 : 3'd2;
        if (e.err) e.lat = 1;
        else if (st) begin
            e.lat = 2;
            e.wm = 1;
            for (int i = 0; i < sz; i++) ref_b[al+i] = wd[8*i +: 8];
        end else begin
            e.lat = RL + 1;
            v = 0;
            for (int i = 0; i < sz; i++) v = v | (32'(ref_b[al+i]) << (8*i));
            if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
            e.rdata = v;
        end
        return e;
    endfunction

    // One transaction: handshake, scramble the request inputs, then watch up to 20 cycles
    task automatic run_req(input string n, input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input exp_t e);
        int lat, wm, busy_rdy, sz;
        logic [31:0] rd, wa, wdo, ra;
        logic er;
        logic [2:0] fo;
        lat = 0; wm = 0; busy_rdy = 0; rd = 0; er = 0; wa = 0; wdo = 0; ra = 0; fo = 0;
        @(negedge clk);
        chk({n, "_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (req_ready) busy_rdy++;
            if (write_mem) begin
                wm++; wa = write_address; fo = funct3; wdo = write_data;
                sz = funct3[1:0] == 2'd0 ? 1 : funct3[1:0] == 2'd1 ? 2 : 4;
                for (int i = 0; i < sz; i++) dmem[int'(write_address[7:0]) + i] = write_data[8*i +: 8];
            end
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; er = rsp_err; ra = read_address;
                break;
            end
        end
        chk({n, "_latency"}, 32'(lat), 32'(e.lat));
        chk({n, "_rdata"}, rd, e.rdata);
        chk({n, "_err"}, 32'(er), 32'(e.err));
        chk({n, "_wm_cycles"}, 32'(wm), 32'(e.wm));
        chk({n, "_ready_busy"}, 32'(busy_rdy), 32'd0);
        if (e.wm != 0) begin
            chk({n, "_waddr"}, wa, e.waddr);
            chk({n, "_funct3"}, 32'(fo), 32'(e.fo));
            chk({n, "_wdata"}, wdo, wd);
        end
        if (!st && !e.err) chk({n, "_raddr"}, ra, e.raddr);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            dmem[int'(a[7:2]) * 4 + i] = w[8*i +: 8];
            ref_b[int'(a[7:2]) * 4 + i] = w[8*i +: 8];
        end
    endtask

    initial begin
        exp_t e, m;
        logic [2:0] sf3 [6];
        logic st;
        logic [2:0] f3;
        logic [31:0] a, wd;
        int seen, nmis;
        sf3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 256; i++) begin
            dmem[i] = 8'($urandom);
            ref_b[i] = dmem[i];
        end
        tv[0]  = '{1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, RL+1, 0, 32'h0, 3'd0};
        tv[1]  = '{1'b0, 3'd0, 32'h13, 32'h0, 32'h80FF0000, 32'hFFFFFF80, 1'b0, RL+1, 0, 32'h0, 3'd0};
        tv[2]  = '{1'b0, 3'd4, 32'h13, 32'h0, 32'h80FF0000, 32'h00000080, 1'b0, RL+1, 0, 32'h0, 3'd0};
        tv[3]  = '{1'b0, 3'd1, 32'h12, 32'h0, 32'h80011234, 32'hFFFF8001, 1'b0, RL+1, 0, 32'h0, 3'd0};
        tv[4]  = '{1'b0, 3'd5, 32'h12, 32'h0, 32'h80011234, 32'h00008001, 1'b0, RL+1, 0, 32'h0, 3'd0};
        tv[5]  = '{1'b0, 3'd0, 32'h12, 32'h0, 32'h80FF0000, 32'hFFFFFFFF, 1'b0, RL+1, 0, 32'h0, 3'd0};
        tv[6]  = '{1'b0, 3'd4, 32'h11, 32'h0, 32'h80FF0000, 32'h00000000, 1'b0, RL+1, 0, 32'h0, 3'd0};
        tv[7]  = '{1'b0, 3'd1, 32'h10, 32'h0, 32'h80011234, 32'h00001234, 1'b0, RL+1, 0, 32'h0, 3'd0};
        tv[8]  = '{1'b0, 3'd3, 32'h14, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, RL+1, 0, 32'h0, 3'd0};
        tv[9]  = '{1'b0, 3'd7, 32'h18, 32'h0, 32'h01020304, 32'h01020304, 1'b0, RL+1, 0, 32'h0, 3'd0};
        tv[10] = '{1'b1, 3'd0, 32'h21, 32'h000000AB, 32'h0, 32'h0, 1'b0, 2, 1, 32'h21, 3'd0};
        tv[11] = '{1'b1, 3'd1, 32'h2A, 32'h1234BEEF, 32'h0, 32'h0, 1'b0, 2, 1, 32'h2A, 3'd1};
        tv[12] = '{1'b1, 3'd6, 32'h2C, 32'h55667788, 32'h0, 32'h0, 1'b0, 2, 1, 32'h2C, 3'd2};
`ifdef LSU_MISALIGN_TRAP_EN
        tv[13] = '{1'b0, 3'd2, 32'h22, 32'h0, 32'h11223344, 32'h0, 1'b1, 1, 0, 32'h0, 3'd0};
        tv[14] = '{1'b0, 3'd1, 32'h23, 32'h0, 32'hA5B6C7D8, 32'h0, 1'b1, 1, 0, 32'h0, 3'd0};
        tv[15] = '{1'b1, 3'd2, 32'h26, 32'h99, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 3'd0};
`else
        tv[13] = '{1'b0, 3'd2, 32'h22, 32'h0, 32'h11223344, 32'h11223344, 1'b0, RL+1, 0, 32'h0, 3'd0};
        tv[14] = '{1'b0, 3'd1, 32'h23, 32'h0, 32'hA5B6C7D8, 32'hFFFFA5B6, 1'b0, RL+1, 0, 32'h0, 3'd0};
        tv[15] = '{1'b1, 3'd2, 32'h26, 32'h99, 32'h0, 32'h0, 1'b0, 2, 1, 32'h24, 3'd2};
`endif
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            preload(tv[i].addr, tv[i].word);
            m = model(tv[i].st, tv[i].f3, tv[i].addr, tv[i].wd);
            e = '{tv[i].rdata, tv[i].err, tv[i].lat, tv[i].wm, tv[i].waddr, tv[i].fo, tv[i].addr & 32'hFFFFFFFC};
            run_req($sformatf("vec%0d", i), tv[i].st, tv[i].f3, tv[i].addr, tv[i].wd, e);
        end

        // Reset during LOAD_WAIT: everything returns to reset values at once, no response follows
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset("abort_load");
        seen = 0;
        repeat (3) @(negedge clk) if (rsp_valid) seen++;
        rst = 1'b0;
        repeat (3) @(negedge clk) if (rsp_valid) seen++;
        chk("abort_load_no_rsp", 32'(seen), 32'd0);
        e = model(1'b0, 3'd2, 32'h40, 32'h0);
        run_req("after_abort_load", 1'b0, 3'd2, 32'h40, 32'h0, e);

        // Reset during STORE: write_mem drops asynchronously
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h50; req_wdata = 32'h5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("abort_store_wm_before", 32'(write_mem), 32'd1);
        #2 rst = 1'b1;
        #1 chk("abort_store_wm_after", 32'(write_mem), 32'd0);
        seen = 0;
        repeat (2) @(negedge clk) if (rsp_valid || write_mem) seen++;
        rst = 1'b0;
        repeat (3) @(negedge clk) if (rsp_valid || write_mem) seen++;
        chk("abort_store_quiet", 32'(seen), 32'd0);

        for (int t = 0; t < 200; t++) begin
            st = 1'($urandom);
            f3 = st ? sf3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255));
            wd = $urandom;
            e  = model(st, f3, a, wd);
            run_req($sformatf("rnd%0d", t), st, f3, a, wd, e);
        end

        nmis = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== ref_b[i]) nmis++;
        chk("mem_image", 32'(nmis), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
